// File: rtl/tt_mux_select_seq.sv
// ----------------------------------------------------------------------------
// tt_mux_select_seq
//
// Drives the three-wire mux control interface (ctrl_sel_rst_n, ctrl_sel_inc,
// ctrl_ena) so that the mux selects the project at target_addr. A selection
// runs: disable, optional address-counter reset, N increment pulses, enable.
// The block tracks the address the mux counter holds. When that address is
// known and not above the target, it skips the reset and only steps forward.
//
// Ports:
//   clk             clock
//   rst_n           asynchronous active-low reset
//   start           select target_addr (accepted only in IDLE)
//   abort           cancel any in-progress sequence (wins over start)
//   target_addr     project address to select, sampled with start
//   ctrl_sel_rst_n  mux address-counter reset, active-low
//   ctrl_sel_inc    mux address-counter increment (mux counts on rising edge)
//   ctrl_ena        mux enable for the selected project
//   busy            a sequence is in progress
//   done            one-cycle pulse when a selection completes
//   cur_addr        address the mux counter holds, as tracked here
//   addr_valid      cur_addr is trustworthy
//
// States:
//   IDLE   | waiting for start; outputs held
//   DIS    | ctrl_ena low; decide between reset path and incremental path
//   RST_LO | ctrl_sel_rst_n low
//   RST_HI | ctrl_sel_rst_n released; mux counter now at 0
//   INC_HI | ctrl_sel_inc high
//   INC_LO | ctrl_sel_inc low; one address step completes on exit
//   EN     | one cycle; raise ctrl_ena, pulse done
// ----------------------------------------------------------------------------
module tt_mux_select_seq #(
    parameter int ADDR_W       = 10,
    parameter int PULSE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] target_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              addr_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIS    = 3'd1,
        RST_LO = 3'd2,
        RST_HI = 3'd3,
        INC_HI = 3'd4,
        INC_LO = 3'd5,
        EN     = 3'd6
    } state_t;

    localparam int              PH_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(PULSE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              addr_valid_q, addr_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sel_rst_n_q, sel_rst_n_d;
    logic              sel_inc_q, sel_inc_d;
    logic              ena_q, ena_d;
    // Set for the one cycle after an abort that landed while the mux reset
    // was asserted; the reset is then released with the counter known at 0.
    logic              rel_q, rel_d;

    logic              phase_last;
    logic [PH_W-1:0]   phase_step;
    logic [ADDR_W-1:0] rem_n;

    assign phase_last = (phase_q == '0);
    // Timed states reload the dwell counter on exit, otherwise count down.
    assign phase_step = phase_last ? PH_LOAD : (phase_q - PH_W'(1));

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        tgt_d        = tgt_q;
        rem_d        = rem_q;
        cur_addr_d   = cur_addr_q;
        addr_valid_d = addr_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        sel_rst_n_d  = sel_rst_n_q;
        sel_inc_d    = sel_inc_q;
        ena_d        = ena_q;
        rel_d        = 1'b0;
        rem_n        = '0;

        if (rel_q) begin
            sel_rst_n_d  = 1'b1;
            cur_addr_d   = '0;
            addr_valid_d = 1'b1;
        end

        if (abort) begin
            state_d      = IDLE;
            phase_d      = '0;
            ena_d        = 1'b0;
            sel_inc_d    = 1'b0;
            busy_d       = 1'b0;
            addr_valid_d = 1'b0;
            if (!sel_rst_n_q) begin
                // Hold the mux reset one more cycle so the reset pulse is not
                // cut short; release happens through rel_q.
                sel_rst_n_d = 1'b0;
                rel_d       = 1'b1;
            end else begin
                sel_rst_n_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        tgt_d   = target_addr;
                        busy_d  = 1'b1;
                        phase_d = PH_LOAD;
                        state_d = DIS;
                    end
                end

                DIS: begin
                    ena_d   = 1'b0;
                    phase_d = phase_step;
                    if (phase_last) begin
                        if (addr_valid_q && (tgt_q >= cur_addr_q)) begin
                            rem_n   = tgt_q - cur_addr_q;
                            rem_d   = rem_n;
                            state_d = (rem_n == '0) ? EN : INC_HI;
                        end else begin
                            state_d = RST_LO;
                        end
                    end
                end

                RST_LO: begin
                    sel_rst_n_d = 1'b0;
                    phase_d     = phase_step;
                    if (phase_last) begin
                        state_d = RST_HI;
                    end
                end

                RST_HI: begin
                    sel_rst_n_d = 1'b1;
                    phase_d     = phase_step;
                    if (phase_last) begin
                        cur_addr_d = '0;
                        rem_d      = tgt_q;
                        state_d    = (tgt_q == '0) ? EN : INC_HI;
                    end
                end

                INC_HI: begin
                    sel_inc_d = 1'b1;
                    phase_d   = phase_step;
                    if (phase_last) begin
                        state_d = INC_LO;
                    end
                end

                INC_LO: begin
                    sel_inc_d = 1'b0;
                    phase_d   = phase_step;
                    if (phase_last) begin
                        rem_n      = rem_q - ADDR_W'(1);
                        rem_d      = rem_n;
                        cur_addr_d = cur_addr_q + ADDR_W'(1);
                        state_d    = (rem_n == '0) ? EN : INC_HI;
                    end
                end

                EN: begin
                    ena_d        = 1'b1;
                    done_d       = 1'b1;
                    addr_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            tgt_q        <= '0;
            rem_q        <= '0;
            cur_addr_q   <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sel_rst_n_q  <= 1'b0;
            sel_inc_q    <= 1'b0;
            ena_q        <= 1'b0;
            rel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            tgt_q        <= tgt_d;
            rem_q        <= rem_d;
            cur_addr_q   <= cur_addr_d;
            addr_valid_q <= addr_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sel_rst_n_q  <= sel_rst_n_d;
            sel_inc_q    <= sel_inc_d;
            ena_q        <= ena_d;
            rel_q        <= rel_d;
        end
    end

    assign ctrl_sel_rst_n = sel_rst_n_q;
    assign ctrl_sel_inc   = sel_inc_q;
    assign ctrl_ena       = ena_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cur_addr       = cur_addr_q;
    assign addr_valid     = addr_valid_q;

endmodule

// File: tb/tb_tt_mux_select_seq.sv
// ----------------------------------------------------------------------------
// tb_tt_mux_select_seq
//
// Directed bench for tt_mux_select_seq with ADDR_W=10, PULSE_CYCLES=2.
// Cycle 0 is the edge that samples start; done is expected high after edge
// 1 + 2*(3 + 2*tgt) on the reset path and 1 + 2*(1 + 2*delta) incrementally.
// ----------------------------------------------------------------------------
module tb_tt_mux_select_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [9:0] target_addr;
    logic       ctrl_sel_rst_n;
    logic       ctrl_sel_inc;
    logic       ctrl_ena;
    logic       busy;
    logic       done;
    logic [9:0] cur_addr;
    logic       addr_valid;

    int n_checks = 0;
    int n_fail   = 0;

    tt_mux_select_seq #(
        .ADDR_W      (10),
        .PULSE_CYCLES(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .target_addr   (target_addr),
        .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .ctrl_sel_inc  (ctrl_sel_inc),
        .ctrl_ena      (ctrl_ena),
        .busy          (busy),
        .done          (done),
        .cur_addr      (cur_addr),
        .addr_valid    (addr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue start for target t, follow the sequence to done and check timing,
    // pulse counts and final state. inj_cyc >= 0 pulses a second start
    // (target 9) mid-sequence, which must be ignored.
    task automatic run_seq(input int t, input int exp_done, input int exp_rls,
                           input int exp_inc, input int inj_cyc, input string tag);
        int   cyc;
        int   rls;
        int   incs;
        int   lo_ena;
        logic pr;
        logic pi;
        @(negedge clk);
        target_addr = 10'(t);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cyc    = 0;
        rls    = 0;
        incs   = 0;
        lo_ena = 0;
        pr     = ctrl_sel_rst_n;
        pi     = ctrl_sel_inc;
        chk({tag, " busy_at_start"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && cyc < 400) begin
            if (cyc == inj_cyc) begin
                target_addr = 10'd9;
                start       = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (!pr && ctrl_sel_rst_n) rls++;
            if (!pi && ctrl_sel_inc) incs++;
            if (!ctrl_ena) lo_ena++;
            pr = ctrl_sel_rst_n;
            pi = ctrl_sel_inc;
        end
        chk({tag, " done_cycle"}, 32'(cyc), 32'(exp_done));
        chk({tag, " rst_releases"}, 32'(rls), 32'(exp_rls));
        chk({tag, " inc_pulses"}, 32'(incs), 32'(exp_inc));
        chk({tag, " ena_low_cycles"}, 32'(lo_ena), 32'(exp_done - 1));
        chk({tag, " cur_addr"}, 32'(cur_addr), 32'(t));
        chk({tag, " addr_valid"}, 32'(addr_valid), 32'd1);
        chk({tag, " ctrl_ena"}, 32'(ctrl_ena), 32'd1);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_single"}, 32'(done), 32'd0);
    endtask

    initial begin
        int   cyc;
        int   incs;
        logic pi;
        logic seen_done;

        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        target_addr = '0;
        #22;
        chk("rst ctrl_sel_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
        chk("rst ctrl_sel_inc", 32'(ctrl_sel_inc), 32'd0);
        chk("rst ctrl_ena", 32'(ctrl_ena), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst cur_addr", 32'(cur_addr), 32'd0);
        chk("rst addr_valid", 32'(addr_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full reset path, incremental step, downward target, same target.
        run_seq(3, 19, 1, 3, -1, "t1");
        run_seq(5, 11, 0, 2, -1, "t2");
        run_seq(2, 15, 1, 2, -1, "t3");
        run_seq(2, 3, 0, 0, -1, "t4");

        // Abort during the second increment-high phase of target 4.
        @(negedge clk);
        target_addr = 10'd4;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        incs  = 0;
        pi    = ctrl_sel_inc;
        while (incs < 2 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!pi && ctrl_sel_inc) incs++;
            pi = ctrl_sel_inc;
        end
        chk("t5 second_inc_seen", 32'(incs), 32'd2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t5 abort inc", 32'(ctrl_sel_inc), 32'd0);
        chk("t5 abort ena", 32'(ctrl_ena), 32'd0);
        chk("t5 abort addr_valid", 32'(addr_valid), 32'd0);
        chk("t5 abort busy", 32'(busy), 32'd0);
        chk("t5 abort rst_n", 32'(ctrl_sel_rst_n), 32'd1);
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        chk("t5 no_done_after_abort", 32'(seen_done), 32'd0);
        chk("t5 idle_busy", 32'(busy), 32'd0);
        run_seq(1, 11, 1, 1, -1, "t5b");

        // Abort while the mux reset is asserted: reset held one more cycle,
        // then released with the counter known to be 0.
        @(negedge clk);
        target_addr = 10'd0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (ctrl_sel_rst_n !== 1'b0 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t8 rst_low_cycle", 32'(cyc), 32'd3);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t8 rst_held", 32'(ctrl_sel_rst_n), 32'd0);
        chk("t8 busy", 32'(busy), 32'd0);
        chk("t8 addr_valid_low", 32'(addr_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t8 rst_released", 32'(ctrl_sel_rst_n), 32'd1);
        chk("t8 addr_valid", 32'(addr_valid), 32'd1);
        chk("t8 cur_addr", 32'(cur_addr), 32'd0);
        chk("t8 no_done", 32'(done), 32'd0);

        // Start while busy is ignored: result still target 2 on time.
        run_seq(2, 11, 0, 2, 3, "t6");

        // start and abort together in IDLE: abort wins, start dropped.
        @(negedge clk);
        target_addr = 10'd7;
        start       = 1'b1;
        abort       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("t9 busy", 32'(busy), 32'd0);
        chk("t9 cur_addr", 32'(cur_addr), 32'd2);
        chk("t9 ena", 32'(ctrl_ena), 32'd0);
        chk("t9 addr_valid", 32'(addr_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("t9 still_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-sequence.
        @(negedge clk);
        target_addr = 10'd3;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t10 ctrl_sel_rst_n", 32'(ctrl_sel_rst_n), 32'd0);
        chk("t10 ctrl_sel_inc", 32'(ctrl_sel_inc), 32'd0);
        chk("t10 ctrl_ena", 32'(ctrl_ena), 32'd0);
        chk("t10 busy", 32'(busy), 32'd0);
        chk("t10 done", 32'(done), 32'd0);
        chk("t10 cur_addr", 32'(cur_addr), 32'd0);
        chk("t10 addr_valid", 32'(addr_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_seq(1, 11, 1, 1, -1, "t11");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
